// File: rtl/approx_error_monitor.sv
// Sweep-and-compare engine: drives every input pattern onto an exact/approximate partition pair
// and accumulates error metrics in hardware. Optional err_sum output is enabled by ERR_SUM_EN.
module approx_error_monitor #(
   parameter int IN_W   = 7,
   parameter int OUT_W  = 4,
   parameter int SETTLE = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   output logic [IN_W-1:0]                   pi,
   input  logic [OUT_W-1:0]                  po_approx,
   input  logic [OUT_W-1:0]                  po_exact,
   output logic                              busy,
   output logic                              done,
   output logic [IN_W:0]                     err_count,
   output logic [IN_W+$clog2(OUT_W+1)-1:0]   hd_sum,
`ifdef ERR_SUM_EN
   output logic [IN_W+OUT_W-1:0]             err_sum,
`endif
   output logic [OUT_W-1:0]                  max_abs_err
);

   localparam int PC_W  = $clog2(OUT_W + 1);
   localparam int HD_W  = IN_W + PC_W;
   localparam int CNT_W = $clog2(SETTLE + 1);

   typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [IN_W-1:0]    r_pi;
   logic               r_busy;
   logic               r_done;
   logic [IN_W:0]      r_err_count;
   logic [HD_W-1:0]    r_hd_sum;
   logic [OUT_W-1:0]   r_max_abs_err;
   logic               w_clear;
   logic               w_sample;
   logic               w_finish;
   logic               w_last;
   logic [OUT_W-1:0]   w_diff;
   logic [PC_W-1:0]    w_pc;
   logic [OUT_W-1:0]   w_abs;

   function automatic logic [PC_W-1:0] popcount(input logic [OUT_W-1:0] v);
      logic [PC_W-1:0] n;
      n = '0;
      for (int i = 0; i < OUT_W; i++) n = n + PC_W'(v[i]);
      return n;
   endfunction

   // Difference taken one bit wider so the sign is visible before folding to magnitude.
   function automatic logic [OUT_W-1:0] abs_diff(input logic [OUT_W-1:0] a,
                                                input logic [OUT_W-1:0] b);
      logic [OUT_W:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (d[OUT_W]) d = -d;
      return d[OUT_W-1:0];
   endfunction

   assign w_diff = po_approx ^ po_exact;
   assign w_pc   = popcount(w_diff);
   assign w_abs  = abs_diff(po_approx, po_exact);
   assign w_last = (r_pi == {IN_W{1'b1}});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // DONE waits one cycle before raising done/dropping busy; restart is only honoured once done is up.
   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      w_sample    = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_clear     = 1'b1;
               w_state_nxt = APPLY;
            end
         end
         APPLY: begin
            if (r_cnt == CNT_W'(1)) w_state_nxt = SAMPLE;
         end
         SAMPLE: begin
            w_sample = 1'b1;
            w_state_nxt = w_last ? DONE : APPLY;
         end
         DONE: begin
            if (r_done && start) begin
               w_clear     = 1'b1;
               w_state_nxt = APPLY;
            end else if (!r_done) begin
               w_finish = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_pi   <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else if (w_clear) begin
         r_cnt  <= CNT_W'(SETTLE);
         r_pi   <= '0;
         r_busy <= 1'b1;
         r_done <= 1'b0;
      end else if (w_sample) begin
         if (!w_last) begin
            r_pi  <= r_pi + 1'b1;
            r_cnt <= CNT_W'(SETTLE);
         end
      end else if (w_finish) begin
         r_busy <= 1'b0;
         r_done <= 1'b1;
      end else if (r_state == APPLY) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_count   <= '0;
         r_hd_sum      <= '0;
         r_max_abs_err <= '0;
      end else if (w_clear) begin
         r_err_count   <= '0;
         r_hd_sum      <= '0;
         r_max_abs_err <= '0;
      end else if (w_sample) begin
         r_err_count <= r_err_count + (IN_W+1)'(w_diff != '0);
         r_hd_sum    <= r_hd_sum + HD_W'(w_pc);
         if (w_abs > r_max_abs_err) r_max_abs_err <= w_abs;
      end
   end

`ifdef ERR_SUM_EN
   logic [IN_W+OUT_W-1:0] r_err_sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_err_sum <= '0;
      else if (w_clear)  r_err_sum <= '0;
      else if (w_sample) r_err_sum <= r_err_sum + (IN_W+OUT_W)'(w_abs);
   end

   assign err_sum = r_err_sum;
`endif

   assign pi          = r_pi;
   assign busy        = r_busy;
   assign done        = r_done;
   assign err_count   = r_err_count;
   assign hd_sum      = r_hd_sum;
   assign max_abs_err = r_max_abs_err;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Randomised bench for approx_error_monitor: partitions are lookup tables indexed by pi,
// expected metrics come from a whole-table reference model.
module tb_approx_error_monitor;
   localparam int IN_W  = 7;
   localparam int OUT_W = 4;
   localparam int N     = 1 << IN_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        start1 = 1'b0, start3 = 1'b0;
   logic [6:0]  pi1, pi3;
   logic [3:0]  pa1, pe1, pa3, pe3;
   logic        busy1, done1, busy3, done3;
   logic [7:0]  ec1, ec3;
   logic [9:0]  hd1, hd3;
   logic [3:0]  mx1, mx3;
`ifdef ERR_SUM_EN
   logic [10:0] es1, es3;
`endif

   logic [3:0] tab_e [N];
   logic [3:0] tab_a [N];

   assign pe1 = tab_e[pi1];
   assign pa1 = tab_a[pi1];
   assign pe3 = tab_e[pi3];
   assign pa3 = tab_a[pi3];

   approx_error_monitor #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .pi(pi1),
      .po_approx(pa1), .po_exact(pe1), .busy(busy1), .done(done1),
      .err_count(ec1), .hd_sum(hd1),
`ifdef ERR_SUM_EN
      .err_sum(es1),
`endif
      .max_abs_err(mx1));

   approx_error_monitor #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .pi(pi3),
      .po_approx(pa3), .po_exact(pe3), .busy(busy3), .done(done3),
      .err_count(ec3), .hd_sum(hd3),
`ifdef ERR_SUM_EN
      .err_sum(es3),
`endif
      .max_abs_err(mx3));

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   int t0     = 0;
   int lat;
   int m_err, m_hd, m_max, m_sum;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model();
      int d;
      m_err = 0; m_hd = 0; m_max = 0; m_sum = 0;
      for (int i = 0; i < N; i++) begin
         d = int'(tab_a[i]) - int'(tab_e[i]);
         if (d < 0) d = -d;
         if (tab_a[i] != tab_e[i]) m_err++;
         m_hd  += $countones(tab_a[i] ^ tab_e[i]);
         m_sum += d;
         if (d > m_max) m_max = d;
      end
   endtask

   task automatic fill(input int mode);
      for (int i = 0; i < N; i++) begin
         tab_e[i] = 4'($urandom);
         case (mode)
            0: tab_a[i] = tab_e[i];
            1: tab_a[i] = tab_e[i] ^ 4'b0001;
            2: tab_a[i] = (i == N-1) ? (tab_e[i] ^ 4'b1000) : tab_e[i];
            3: begin tab_e[i] = 4'(i); tab_a[i] = 4'd0; end
            4: tab_a[i] = 4'($urandom);
            default: tab_a[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : tab_e[i];
         endcase
      end
   endtask

   task automatic pulse_start(input bit sel);
      @(negedge clk);
      if (sel) start3 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      start3 = 1'b0;
      t0 = cycle;
   endtask

   task automatic wait_done(input bit sel, output int l);
      l = -1;
      for (int i = 0; i < 3000; i++) begin
         if (sel ? done3 : done1) begin
            l = cycle - t0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_pi(input int v);
      for (int i = 0; i < 3000; i++) begin
         if (pi1 == 7'(v) && busy1) break;
         @(negedge clk);
      end
      chk("wait_pi", 64'(pi1), 64'(v));
   endtask

   task automatic check_final(input bit sel, input string tag);
      model();
      chk({tag, "_err_count"}, 64'(sel ? ec3 : ec1), 64'(m_err));
      chk({tag, "_hd_sum"},    64'(sel ? hd3 : hd1), 64'(m_hd));
      chk({tag, "_max_abs"},   64'(sel ? mx3 : mx1), 64'(m_max));
      chk({tag, "_pi_end"},    64'(sel ? pi3 : pi1), 64'(N-1));
      chk({tag, "_busy"},      64'(sel ? busy3 : busy1), 64'(0));
      chk({tag, "_done"},      64'(sel ? done3 : done1), 64'(1));
`ifdef ERR_SUM_EN
      chk({tag, "_err_sum"},   64'(sel ? es3 : es1), 64'(m_sum));
`endif
   endtask

   task automatic sweep(input bit sel, input string tag);
      pulse_start(sel);
      wait_done(sel, lat);
      chk({tag, "_latency"}, 64'(lat), sel ? 64'(513) : 64'(257));
      check_final(sel, tag);
   endtask

   initial begin
      #12;
      chk("rst_pi",   64'(pi1),   64'(0));
      chk("rst_busy", 64'(busy1), 64'(0));
      chk("rst_done", 64'(done1), 64'(0));
      chk("rst_err",  64'(ec1),   64'(0));
      chk("rst_hd",   64'(hd1),   64'(0));
      chk("rst_max",  64'(mx1),   64'(0));
      @(negedge clk);
      rst = 1'b0;

      fill(0); sweep(0, "equal");
      fill(1); sweep(0, "xor1");
      fill(2); sweep(0, "last_only");
      fill(3); sweep(0, "ramp_zero");
      for (int k = 0; k < 3; k++) begin
         fill(4); sweep(0, "rand");
         fill(5); sweep(0, "sparse");
      end

      fill(1);
      pulse_start(0);
      wait_pi(40);
      #2 rst = 1'b1;
      #1;
      chk("midrst_pi",   64'(pi1),   64'(0));
      chk("midrst_busy", 64'(busy1), 64'(0));
      chk("midrst_done", 64'(done1), 64'(0));
      chk("midrst_err",  64'(ec1),   64'(0));
      chk("midrst_hd",   64'(hd1),   64'(0));
      chk("midrst_max",  64'(mx1),   64'(0));
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_idle_busy", 64'(busy1), 64'(0));
      fill(0); sweep(0, "after_rst");

      fill(4);
      pulse_start(0);
      wait_pi(10);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      wait_done(0, lat);
      chk("busy_start_latency", 64'(lat), 64'(257));
      check_final(0, "busy_start");

      fill(1);
      pulse_start(0);
      chk("rerun_done_drop", 64'(done1), 64'(0));
      chk("rerun_busy",      64'(busy1), 64'(1));
      chk("rerun_err_clr",   64'(ec1),   64'(0));
      chk("rerun_pi",        64'(pi1),   64'(0));
      wait_done(0, lat);
      chk("rerun_latency", 64'(lat), 64'(257));
      check_final(0, "rerun");

      fill(4); sweep(1, "settle3");
      fill(5); sweep(1, "settle3b");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
